tarb3_1: RTL and testbench

Three-requester round-robin arbiter that produces the one-hot 3-bit select consumed by the CPU's one-hot 3:1 datapath muxes. It sits in front of a shared resource such as the memory port; instruction fetch, load/store and debug/DMA are the typical requesters. It issues a registered one-hot grant, holds it for the whole transaction, and rotates priority on completion so no requester starves.

---
 rtl/tarb3_1_pkg.sv | 13 +
 rtl/tarb3_1_tpick3.sv | 32 +++
 rtl/tarb3_1.sv | 69 ++++++
 tb/tb_tarb3_1.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tarb3_1_pkg.sv
// Shared state encoding and reset constants for the tarb3_1 arbiter.
// Constants only; no logic, no latency, no flow control.
package tarb3_1_pkg;

  typedef enum logic {
    TARB_IDLE = 1'b0,
    TARB_BUSY = 1'b1
  } tarb_state_t;

  // src1 (bit0) is first in line after reset
  localparam logic [2:0] TARB_LAST_RST = 3'b100;

endpackage

// File: rtl/tarb3_1_tpick3.sv
// Rotating-priority picker: one-hot winner, search starts after last, wraps 2->0.
// Purely combinational, zero latency; win is 000 when nothing requests.
module tpick3
  import tarb3_1_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] last,
  output logic [2:0] win
);

  always_comb begin
    win = 3'b000;
    case (last)
      3'b001: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      3'b010: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/tarb3_1.sv
// 3-way round-robin arbiter, registered one-hot sel held until done; TARB_BACK2BACK_EN
// enables zero-bubble regrant on done. req->sel latency 1 cycle; no backpressure,
// requesters simply wait while another grant is outstanding.
module tarb3_1
  import tarb3_1_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       busy,
  output logic [2:0] last
);

  tarb_state_t state;
  logic [2:0]  pick_last;
  logic [2:0]  win;

  // While busy the current grantee is the priority reference, so a back-to-back
  // pick already sees the rotated order that last is about to take.
  assign pick_last = (state == TARB_BUSY) ? sel : last;

  tpick3 u_pick (
    .req  (req),
    .last (pick_last),
    .win  (win)
  );

  assign busy = (state == TARB_BUSY);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= TARB_IDLE;
      sel   <= 3'b000;
      last  <= TARB_LAST_RST;
    end else begin
      case (state)
        TARB_IDLE: begin
          if (|req) begin
            sel   <= win;
            state <= TARB_BUSY;
          end
        end
        TARB_BUSY: begin
          if (done) begin
            last <= sel;
`ifdef TARB_BACK2BACK_EN
            if (|req) begin
              sel <= win;
            end else begin
              sel   <= 3'b000;
              state <= TARB_IDLE;
            end
`else
            sel   <= 3'b000;
            state <= TARB_IDLE;
`endif
          end
        end
        default: begin
          sel   <= 3'b000;
          state <= TARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tarb3_1.sv
// Bench for tarb3_1: directed vector table, done+req corner sequence, then random
// traffic against an index-based round-robin model. Honours TARB_BACK2BACK_EN.
module tb_tarb3_1;

`ifdef TARB_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] req;
  logic       done;
  logic [2:0] sel;
  logic       busy;
  logic [2:0] last;

  int tests = 0;
  int fails = 0;

  tarb3_1 dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .done   (done),
    .sel    (sel),
    .busy   (busy),
    .last   (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [2:0] req;
    logic       done;
    logic [2:0] e_sel;
    logic       e_busy;
    logic [2:0] e_last;
  } vec_t;

  vec_t tbl[30];

  always @(negedge clk) begin
    tests++;
    if (!$onehot0(sel)) begin
      fails++;
      $display("FAIL onehot0: sel=%b is multi-hot", sel);
    end
  end

  task automatic chk(input string nm, input logic [2:0] es, input logic eb, input logic [2:0] el);
    tests++;
    if (sel !== es || busy !== eb || last !== el) begin
      fails++;
      $display("FAIL %s: got sel=%b busy=%b last=%b, want sel=%b busy=%b last=%b",
               nm, sel, busy, last, es, eb, el);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] q, input logic d);
    resetn = r;
    req    = q;
    done   = d;
    @(posedge clk);
    #1;
  endtask

  // Reference: grant/last held as source indices; -1 means no grant.
  function automatic int rr_pick(input logic [2:0] q, input int l);
    for (int k = 1; k <= 3; k++) begin
      if (q[(l + k) % 3]) return (l + k) % 3;
    end
    return -1;
  endfunction

  initial begin
    int g, l;
    logic r, d;
    logic [2:0] q, es;

    // fairness rotation
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b100};
    tbl[1]  = '{1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 3'b100};
    tbl[2]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    tbl[3]  = '{1'b1, 3'b111, 1'b0, 3'b010, 1'b1, 3'b001};
    tbl[4]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b010};
    tbl[5]  = '{1'b1, 3'b111, 1'b0, 3'b100, 1'b1, 3'b010};
    tbl[6]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b100};
    tbl[7]  = '{1'b1, 3'b111, 1'b0, 3'b001, 1'b1, 3'b100};
    tbl[8]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    // lone requester src3, three transactions
    tbl[9]  = '{1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 3'b001};
    tbl[10] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b100};
    tbl[11] = '{1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 3'b100};
    tbl[12] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b100};
    tbl[13] = '{1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 3'b100};
    tbl[14] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b100};
    // grant held while requester drops
    tbl[15] = '{1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 3'b100};
    tbl[16] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 3'b100};
    tbl[17] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 3'b100};
    tbl[18] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 3'b100};
    tbl[19] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 3'b100};
    tbl[20] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b010};
    tbl[21] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'b010};
    // done while idle is ignored
    tbl[22] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    tbl[23] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    tbl[24] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    // reset mid-transaction
    tbl[25] = '{1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 3'b001};
    tbl[26] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 3'b100};
    tbl[27] = '{1'b1, 3'b011, 1'b0, 3'b001, 1'b1, 3'b100};
    tbl[28] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001};
    tbl[29] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'b001};

    resetn = 1'b0;
    req    = 3'b000;
    done   = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].rstn, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_last);
    end

    // done and req=101 together while sel=001
    step(1'b1, 3'b101, 1'b1);
    if (B2B) begin
      chk("b2b_regrant", 3'b100, 1'b1, 3'b001);
    end else begin
      chk("bubble_idle", 3'b000, 1'b0, 3'b001);
      step(1'b1, 3'b101, 1'b0);
      chk("bubble_grant", 3'b100, 1'b1, 3'b001);
    end
    step(1'b1, 3'b000, 1'b1);
    chk("b2b_close", 3'b000, 1'b0, 3'b100);

    // random traffic against the index model
    g = -1;
    l = 2;
    for (int c = 0; c < 3000; c++) begin
      r = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      q = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 2) == 0);
      step(r, q, d);
      if (!r) begin
        g = -1;
        l = 2;
      end else if (g < 0) begin
        g = rr_pick(q, l);
      end else if (d) begin
        l = g;
        g = B2B ? rr_pick(q, l) : -1;
      end
      es = (g < 0) ? 3'b000 : 3'(1 << g);
      chk($sformatf("rand%0d", c), es, g >= 0, 3'(1 << l));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
